// File: rtl/hitmark_ctrl.sv
// hitmark_ctrl
// Turns a one-cycle hammer-hit strobe into the origin and control word for
// the 16x16 hit-mark sprite core. The mark is centred on the hit point,
// animates through sprite ids 0..3 and hides itself after HOLD_FRAMES
// frames. Origin and sprite id only change on a frame boundary, so the
// sprite core never draws a torn mark.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   x, y     - current scan coordinates from the video sync core
//   hit      - one-cycle hit strobe
//   hit_x    - hit point x (centre of the mark)
//   hit_y    - hit point y (centre of the mark)
//   hit_kind - colour select, copied to ctrl[4:3]
//   x0, y0   - registered sprite origin (x0 = OFF_X while hidden)
//   ctrl     - registered {colour[1:0], auto=0, sid[1:0]}
//   active   - high while the mark is on screen
//   done     - one-cycle pulse when a display expires naturally
module hitmark_ctrl #(
  parameter int HOLD_FRAMES = 32,
  parameter int ANI_FRAMES  = 8,
  parameter int X_MAX       = 624,
  parameter int Y_MAX       = 464,
  parameter int OFF_X       = 2047
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        hit,
  input  logic [10:0] hit_x,
  input  logic [10:0] hit_y,
  input  logic [1:0]  hit_kind,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl,
  output logic        active,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, PEND, SHOW} state_t;

  localparam logic [7:0]  LAST_CNT = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  ANI_DIV  = 8'(ANI_FRAMES);
  localparam logic [10:0] HIDDEN_X = 11'(OFF_X);

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, cnt_nxt;
  logic [10:0] lat_x, lat_x_nxt;
  logic [10:0] lat_y, lat_y_nxt;
  logic [1:0]  lat_kind, lat_kind_nxt;
  logic [10:0] x0_nxt, y0_nxt;
  logic [4:0]  ctrl_nxt;
  logic        active_nxt, done_nxt;
  logic [10:0] x_d1;
  logic        frame_tick;
  logic [10:0] hit_cx, hit_cy;
  logic [10:0] load_x, load_y;
  logic [1:0]  load_kind;
  logic [7:0]  cnt_inc;

  // Move from the hit centre to the sprite's top-left corner and keep the
  // whole 16x16 sprite on screen. Done in 12-bit signed so a hit near the
  // left/top edge goes negative instead of wrapping.
  function automatic logic [10:0] clamp_origin(input logic [10:0] c, input int lim);
    logic signed [11:0] d;
    d = $signed({1'b0, c}) - 12'sd8;
    if (d < 12'sd0)
      return 11'd0;
    else if (d > $signed(12'(lim)))
      return 11'(lim);
    else
      return d[10:0];
  endfunction

  // Sprite id for a given frame count, saturating at the last animation step.
  function automatic logic [1:0] sid_of(input logic [7:0] cnt);
    logic [7:0] q;
    q = cnt / ANI_DIV;
    return (q > 8'd3) ? 2'd3 : q[1:0];
  endfunction

  // The tick fires on the 0->1 step of x on line 0, which happens exactly
  // once per frame regardless of the line length.
  assign frame_tick = (y == 11'd0) && (x == 11'd1) && (x_d1 == 11'd0);

  assign hit_cx  = clamp_origin(hit_x, X_MAX);
  assign hit_cy  = clamp_origin(hit_y, Y_MAX);
  assign cnt_inc = frame_cnt + 8'd1;

  // A hit landing on the same cycle as the PEND tick must be the one shown,
  // so its freshly clamped values bypass the latch.
  assign load_x    = hit ? hit_cx   : lat_x;
  assign load_y    = hit ? hit_cy   : lat_y;
  assign load_kind = hit ? hit_kind : lat_kind;

  // State register plus all display registers; everything is computed in
  // the combinational block below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      lat_x     <= 11'd0;
      lat_y     <= 11'd0;
      lat_kind  <= 2'd0;
      x0        <= HIDDEN_X;
      y0        <= 11'd0;
      ctrl      <= 5'd0;
      active    <= 1'b0;
      done      <= 1'b0;
      x_d1      <= 11'd0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= cnt_nxt;
      lat_x     <= lat_x_nxt;
      lat_y     <= lat_y_nxt;
      lat_kind  <= lat_kind_nxt;
      x0        <= x0_nxt;
      y0        <= y0_nxt;
      ctrl      <= ctrl_nxt;
      active    <= active_nxt;
      done      <= done_nxt;
      x_d1      <= x;
    end
  end

  // Next-state and next-output logic. Everything holds by default; the
  // visible registers only move on a frame tick, while a hit only touches
  // the latch and the state.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = frame_cnt;
    lat_x_nxt    = lat_x;
    lat_y_nxt    = lat_y;
    lat_kind_nxt = lat_kind;
    x0_nxt       = x0;
    y0_nxt       = y0;
    ctrl_nxt     = ctrl;
    active_nxt   = active;
    done_nxt     = 1'b0;

    if (hit) begin
      lat_x_nxt    = hit_cx;
      lat_y_nxt    = hit_cy;
      lat_kind_nxt = hit_kind;
    end

    case (state)
      IDLE: begin
        if (hit)
          state_nxt = PEND;
      end

      PEND: begin
        if (frame_tick) begin
          state_nxt  = SHOW;
          x0_nxt     = load_x;
          y0_nxt     = load_y;
          ctrl_nxt   = {load_kind, 3'b000};
          cnt_nxt    = 8'd0;
          active_nxt = 1'b1;
        end
      end

      SHOW: begin
        // A retrigger beats both the animation step and the expiry, and the
        // old mark stays on screen until the next tick loads the new one.
        if (hit) begin
          state_nxt = PEND;
        end else if (frame_tick) begin
          if (frame_cnt == LAST_CNT) begin
            state_nxt     = IDLE;
            x0_nxt        = HIDDEN_X;
            ctrl_nxt[1:0] = 2'b00;
            active_nxt    = 1'b0;
            done_nxt      = 1'b1;
          end else begin
            cnt_nxt       = cnt_inc;
            ctrl_nxt[1:0] = sid_of(cnt_inc);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
